register_serial_loader: RTL and testbench

- Upstream sequencer for the shift/load `register` block.
- Accepts a parallel word over a valid/ready handshake and can optionally clear the register first.
- Loads the word into the register one bit per clock, using the register's serial-load ctrl codes.
- Drives the register's `ctrl` and `serial_data_input` pins directly and pulses `done` when the register holds the word.

---
 rtl/register_serial_loader.sv | 77 +++++++
 tb/tb_register_serial_loader.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/register_serial_loader.sv
// register_serial_loader: sequences a parallel word into a shift/load register one bit per clock
module register_serial_loader #(
    parameter int WIDTH      = 8,
    parameter bit MSB_INSERT = 1
) (
    input  logic             clk,
    input  logic             async_nreset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_clear,
    input  logic             abort,
    output logic [2:0]       ctrl,
    output logic             serial_data_input,
    output logic             busy,
    output logic             done
);
    localparam int         CW   = $clog2(WIDTH);
    localparam logic [2:0] NONE = 3'd0;
    localparam logic [2:0] CLR  = 3'd1;
    localparam logic [2:0] LOAD = MSB_INSERT ? 3'd3 : 3'd4;

    typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] data, data_d;
    logic [CW-1:0]    cnt, cnt_d, sel;
    logic             accept;

    assign accept   = state == IDLE && in_valid && !abort;
    assign in_ready = state == IDLE;
    assign busy     = state != IDLE;
    // Outputs are computed from the next state so they line up with the state they belong to.
    assign sel      = MSB_INSERT ? cnt_d : CW'(WIDTH - 1) - cnt_d;

    always_comb begin
        state_d = state;
        data_d  = data;
        cnt_d   = cnt;
        if (abort && state != IDLE)
            state_d = IDLE;
        else
            case (state)
                IDLE:
                    if (accept) begin
                        state_d = in_clear ? CLEAR : SHIFT;
                        data_d  = in_data;
                        cnt_d   = '0;
                    end
                CLEAR: state_d = SHIFT;
                SHIFT:
                    if (cnt == CW'(WIDTH - 1))
                        state_d = DONE;
                    else
                        cnt_d = cnt + 1'b1;
                DONE:  state_d = IDLE;
            endcase
    end

    always_ff @(posedge clk or negedge async_nreset) begin
        if (!async_nreset) begin
            state             <= IDLE;
            data              <= '0;
            cnt               <= '0;
            ctrl              <= NONE;
            serial_data_input <= 1'b0;
            done              <= 1'b0;
        end else begin
            state             <= state_d;
            data              <= data_d;
            cnt               <= cnt_d;
            ctrl              <= state_d == CLEAR ? CLR : state_d == SHIFT ? LOAD : NONE;
            serial_data_input <= state_d == SHIFT && data_d[sel];
            done              <= state_d == DONE;
        end
    end
endmodule

// File: tb/tb_register_serial_loader.sv
// tb_register_serial_loader: drives both insertion modes in lockstep against register models
module tb_register_serial_loader;
    logic       clk = 0, async_nreset, in_valid, in_clear, abort, pre;
    logic [7:0] in_data;
    logic       in_ready_m, in_ready_l, sdi_m, sdi_l, busy_m, busy_l, done_m, done_l;
    logic [2:0] ctrl_m, ctrl_l;
    logic [7:0] reg_m = 0, reg_l = 0;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    register_serial_loader #(.WIDTH(8), .MSB_INSERT(1)) u_m (
        .clk(clk), .async_nreset(async_nreset), .in_valid(in_valid), .in_ready(in_ready_m),
        .in_data(in_data), .in_clear(in_clear), .abort(abort), .ctrl(ctrl_m),
        .serial_data_input(sdi_m), .busy(busy_m), .done(done_m)
    );

    register_serial_loader #(.WIDTH(8), .MSB_INSERT(0)) u_l (
        .clk(clk), .async_nreset(async_nreset), .in_valid(in_valid), .in_ready(in_ready_l),
        .in_data(in_data), .in_clear(in_clear), .abort(abort), .ctrl(ctrl_l),
        .serial_data_input(sdi_l), .busy(busy_l), .done(done_l)
    );

    always @(posedge clk) begin
        if (pre) begin
            reg_m <= 8'hFF;
            reg_l <= 8'hFF;
        end else begin
            case (ctrl_m)
                3'd1: reg_m <= 8'h00;
                3'd3: reg_m <= {sdi_m, reg_m[7:1]};
                3'd4: reg_m <= {reg_m[6:0], sdi_m};
                default: ;
            endcase
            case (ctrl_l)
                3'd1: reg_l <= 8'h00;
                3'd3: reg_l <= {sdi_l, reg_l[7:1]};
                3'd4: reg_l <= {reg_l[6:0], sdi_l};
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_cycle(input string tag, input logic [2:0] cm, input logic [2:0] cl,
                                input logic sm, input logic sl, input logic dn, input logic rdy);
        check({tag, "_ctrl_m"}, ctrl_m, cm);
        check({tag, "_ctrl_l"}, ctrl_l, cl);
        check({tag, "_sdi_m"}, sdi_m, sm);
        check({tag, "_sdi_l"}, sdi_l, sl);
        check({tag, "_done_m"}, done_m, dn);
        check({tag, "_done_l"}, done_l, dn);
        check({tag, "_ready_m"}, in_ready_m, rdy);
        check({tag, "_ready_l"}, in_ready_l, rdy);
        check({tag, "_busy_m"}, busy_m, !rdy);
        check({tag, "_busy_l"}, busy_l, !rdy);
    endtask

    // Scoreboard: every done pulse must match the oldest outstanding word in both registers.
    always @(negedge clk) begin
        if (async_nreset === 1'b1 && (done_m || done_l)) begin
            if (exp_q.size() == 0) begin
                check("sb_pending", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                check("sb_reg_m", reg_m, e);
                check("sb_reg_l", reg_l, e);
            end
        end
    end

    // kind: 0 complete, 1 abort at shift cycle `at`, 2 reset at shift cycle `at`
    task automatic send(input logic [7:0] d, input logic clr, input int kind, input int at,
                        input logic hold);
        int n = 0;
        in_valid = 1;
        in_data  = d;
        in_clear = clr;
        while (!in_ready_m && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", n < 50, 1);
        @(posedge clk);
        #1;
        exp_q.push_back(d);
        in_data  = ~d;
        in_clear = ~clr;
        if (!hold) in_valid = 0;
        if (clr) begin
            @(negedge clk);
            expect_cycle("clear", 3'd1, 3'd1, 0, 0, 0, 0);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            expect_cycle("shift", 3'd3, 3'd4, d[k], d[7-k], 0, 0);
            if (kind != 0 && k == at) begin
                void'(exp_q.pop_back());
                if (kind == 1) begin
                    abort = 1;
                    @(posedge clk);
                    #1 abort = 0;
                    @(negedge clk);
                    expect_cycle("abort", 3'd0, 3'd0, 0, 0, 0, 1);
                end else begin
                    #2 async_nreset = 0;
                    #1 expect_cycle("rst_mid", 3'd0, 3'd0, 0, 0, 0, 1);
                    @(negedge clk);
                    expect_cycle("rst_mid_hold", 3'd0, 3'd0, 0, 0, 0, 1);
                    #2 async_nreset = 1;
                    @(negedge clk);
                end
                in_valid = 0;
                @(negedge clk);
                expect_cycle("after_cut", 3'd0, 3'd0, 0, 0, 0, 1);
                return;
            end
        end
        @(negedge clk);
        expect_cycle("done", 3'd0, 3'd0, 0, 0, 1, 0);
        in_valid = 0;
        @(negedge clk);
        expect_cycle("ready", 3'd0, 3'd0, 0, 0, 0, 1);
    endtask

    initial begin
        async_nreset = 1;
        in_valid     = 0;
        in_data      = 0;
        in_clear     = 0;
        abort        = 0;
        pre          = 0;
        #12 async_nreset = 0;
        #1 expect_cycle("rst_imm", 3'd0, 3'd0, 0, 0, 0, 1);
        repeat (2) @(negedge clk);
        expect_cycle("rst_hold", 3'd0, 3'd0, 0, 0, 0, 1);
        #2 async_nreset = 1;
        @(negedge clk);
        expect_cycle("idle", 3'd0, 3'd0, 0, 0, 0, 1);

        send(8'hA5, 0, 0, 0, 0);

        pre = 1;
        @(posedge clk);
        #1 pre = 0;
        @(negedge clk);
        check("preload_m", reg_m, 8'hFF);
        check("preload_l", reg_l, 8'hFF);
        send(8'h0F, 1, 0, 0, 0);

        send(8'h5A, 0, 1, 3, 0);
        send(8'h3C, 0, 0, 0, 0);

        in_valid = 1;
        in_data  = 8'hC3;
        abort    = 1;
        @(posedge clk);
        #1 abort = 0;
        @(negedge clk);
        expect_cycle("abort_idle", 3'd0, 3'd0, 0, 0, 0, 1);
        send(8'hC3, 0, 0, 0, 1);

        send(8'h99, 1, 2, 4, 0);
        send(8'h81, 0, 0, 0, 0);
        send(8'h6E, 1, 0, 0, 0);

        repeat (3) @(negedge clk);
        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
